// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, payload type and the shared ALU compute function (operands up to 32 bits).
package alu_pkg;

    localparam int ALU_OP_W = 3;
    localparam int ALU_MAXW = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSA = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } op_e;

    typedef logic signed [ALU_MAXW:0] alu_word_t;

    typedef struct packed {
        alu_word_t result;
        logic      ovf;
        logic      illegal;
    } alu_payload_t;

    // Operands arrive already sign-extended to the full word; dataw is the live operand width.
    // The result is zero above bit dataw, so callers keep only result[dataw:0].
    function automatic alu_payload_t alu_compute(input alu_word_t a, input alu_word_t b,
                                                 input op_e op, input int unsigned dataw,
                                                 input logic sat);
        alu_word_t one, hi, lo, narrow, wide, r;
        alu_payload_t p;
        one    = alu_word_t'(1);
        hi     = (one <<< (dataw - 1)) - one;
        lo     = -(one <<< (dataw - 1));
        narrow = (one <<< dataw) - one;
        wide   = (one <<< (dataw + 1)) - one;
        r      = '0;
        p      = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                r     = (op == OP_ADD) ? a + b : a - b;
                p.ovf = (r > hi) || (r < lo);
                if (sat && p.ovf)
                    r = (r > hi) ? hi : lo;
                p.result = r & wide;
            end
            OP_AND:   p.result = a & b & narrow;
            OP_OR:    p.result = (a | b) & narrow;
            OP_XOR:   p.result = (a ^ b) & narrow;
            OP_PASSA: p.result = a & narrow;
            default:  p.illegal = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result valid-ready bus of the pipelined ALU.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int DATAW = 8
);
    logic                i_valid;
    logic                o_ready;
    logic [DATAW-1:0]    i_dataa;
    logic [DATAW-1:0]    i_datab;
    logic [ALU_OP_W-1:0] i_op;
    logic                o_valid;
    logic                i_ready;
    logic [DATAW:0]      o_result;
    logic                o_ovf;
    logic                o_illegal;

    modport master (
        output i_valid, i_dataa, i_datab, i_op, i_ready,
        input  o_ready, o_valid, o_result, o_ovf, o_illegal
    );

    modport slave (
        input  i_valid, i_dataa, i_datab, i_op, i_ready,
        output o_ready, o_valid, o_result, o_ovf, o_illegal
    );
endinterface

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one valid/payload register slice of the ALU pipeline with its advance term.
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    input  logic         i_adv_next,
    output logic         o_adv,
    output logic         o_vld,
    output logic [W-1:0] o_data
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // Load from upstream when empty or when the held item moves on; otherwise hold exactly.
    always_comb begin
        o_adv  = !vld_q || i_adv_next;
        vld_d  = o_adv ? i_vld : vld_q;
        data_d = o_adv ? i_data : data_q;
    end

    // Slice register; reset empties the slot and clears its payload.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign o_vld  = vld_q;
    assign o_data = data_q;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined signed ALU with valid/ready backpressure; ALU_SAT_EN enables ADD/SUB saturation.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATAW       = 8,
    parameter int PIPE_STAGES = 2
) (
    input logic       i_clk,
    input logic       i_rst_n,
    alu_pipe_if.slave bus
);
    localparam int PW = DATAW + 3;

`ifdef ALU_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic          vld  [PIPE_STAGES+1];
    logic [PW-1:0] data [PIPE_STAGES+1];
    logic          adv  [PIPE_STAGES+1];
    alu_word_t     a_x, b_x;

    function automatic logic [PW-1:0] pack(input alu_payload_t p);
        return {p.ovf, p.illegal, p.result[DATAW:0]};
    endfunction

    assign a_x     = {{(ALU_MAXW + 1 - DATAW){bus.i_dataa[DATAW-1]}}, bus.i_dataa};
    assign b_x     = {{(ALU_MAXW + 1 - DATAW){bus.i_datab[DATAW-1]}}, bus.i_datab};
    assign vld[0]  = bus.i_valid;
    assign data[0] = pack(alu_compute(a_x, b_x, op_e'(bus.i_op), DATAW, SAT_EN));
    assign adv[PIPE_STAGES] = bus.i_ready;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        alu_pipe_stage #(.W(PW)) u_stage (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_vld      (vld[k]),
            .i_data     (data[k]),
            .i_adv_next (adv[k+1]),
            .o_adv      (adv[k]),
            .o_vld      (vld[k+1]),
            .o_data     (data[k+1])
        );
    end

    // Ready is forced high while reset is held; anything accepted then is discarded by reset.
    assign bus.o_ready   = adv[0] || !i_rst_n;
    assign bus.o_valid   = vld[PIPE_STAGES];
    assign bus.o_result  = data[PIPE_STAGES][DATAW:0];
    assign bus.o_illegal = data[PIPE_STAGES][PW-2];
    assign bus.o_ovf     = data[PIPE_STAGES][PW-1];
endmodule
